// File: rtl/s_memory_fill.sv
// Sweeps a single-port RAM once per start: fills a pattern, or reads it back and flags the first mismatch.
// Latency: fill done DEPTH+1 cycles after start is accepted, verify done DEPTH+RD_LATENCY+1 cycles after.
// Backpressure: none; one RAM access per cycle, start is ignored while an operation is in flight.
module s_memory_fill #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              verify,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              write_enable,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic              mismatch,
   output logic [ADDR_W-1:0] mismatch_addr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [2:0]        DRAIN_LAST = 3'(RD_LATENCY - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [2:0]        drain_q, drain_d;
   logic              verify_q;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] fill_q;
   logic              mismatch_q;
   logic [ADDR_W-1:0] mm_addr_q;
   logic              accept;
   logic              rd_issue;
   logic [DATA_W-1:0] pat_cur;
   logic              rd_miss;

   // Read-compare delay line: stage k holds the read issued k+1 cycles ago.
   logic [RD_LATENCY-1:0]             tap_vld_q;
   logic [RD_LATENCY-1:0][ADDR_W-1:0] tap_addr_q;
   logic [RD_LATENCY-1:0][DATA_W-1:0] tap_exp_q;

   // Pattern word for sweep address a; reverse cannot underflow since a <= LAST_ADDR.
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        m,
                                                 input logic [DATA_W-1:0] fv);
      logic [DATA_W-1:0] p;
      case (m)
         2'b01:   p = fv;
         2'b10:   p = DATA_W'(LAST_ADDR - a);
         default: p = DATA_W'(a);
      endcase
      return p;
   endfunction

   // Next-state logic and RAM-side outputs; the count saturates at the last address.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      drain_d      = drain_q;
      accept       = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      write_enable = 1'b0;
      address      = '0;
      wr_data      = '0;
      rd_issue     = 1'b0;
      pat_cur      = pattern(count_q, mode_q, fill_q);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               count_d = '0;
               state_d = S_SWEEP;
            end
         end
         S_SWEEP: begin
            busy         = 1'b1;
            address      = count_q;
            write_enable = ~verify_q;
            wr_data      = verify_q ? '0 : pat_cur;
            rd_issue     = verify_q;
            if (count_q == LAST_ADDR) begin
               drain_d = '0;
               state_d = verify_q ? S_DRAIN : S_DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            address = count_q;
            if (drain_q == DRAIN_LAST) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_miss       = tap_vld_q[RD_LATENCY-1] && (rd_data != tap_exp_q[RD_LATENCY-1]);
   assign mismatch      = mismatch_q;
   assign mismatch_addr = mm_addr_q;

   // Control state and operation parameters captured when start is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         drain_q  <= '0;
         verify_q <= 1'b0;
         mode_q   <= 2'b00;
         fill_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         drain_q <= drain_d;
         if (accept) begin
            verify_q <= verify;
            mode_q   <= mode;
            fill_q   <= fill_value;
         end
      end
   end

   // Shift each issued read alongside its expected word until rd_data returns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tap_vld_q  <= '0;
         tap_addr_q <= '0;
         tap_exp_q  <= '0;
      end else begin
         tap_vld_q[0]  <= rd_issue;
         tap_addr_q[0] <= count_q;
         tap_exp_q[0]  <= pat_cur;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tap_vld_q[i]  <= tap_vld_q[i-1];
            tap_addr_q[i] <= tap_addr_q[i-1];
            tap_exp_q[i]  <= tap_exp_q[i-1];
         end
      end
   end

   // Sticky first-mismatch capture, cleared only by a newly accepted start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mismatch_q <= 1'b0;
         mm_addr_q  <= '0;
      end else if (accept) begin
         mismatch_q <= 1'b0;
         mm_addr_q  <= '0;
      end else if (rd_miss && !mismatch_q) begin
         mismatch_q <= 1'b1;
         mm_addr_q  <= tap_addr_q[RD_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_s_memory_fill.sv
// Bench for s_memory_fill: three instances (DEPTH/RD_LATENCY = 256/1, 16/2, 1/4), each with its own RAM model.
// A timeline reference model predicts every output from the cycle count since start was accepted.
// Directed scenarios pin the model with literal expectations; a random phase follows.
module tb_s_memory_fill;

   logic clk;
   logic reset_n;

   logic [2:0]      start_s, verify_s;
   logic [2:0][1:0] mode_s;
   logic [2:0][7:0] fv_s;
   logic [2:0]      busy_w, done_w, we_w, mm_w;
   logic [2:0][7:0] addr_w, wd_w, mma_w;

   int ca [3];
   int cb [3];
   int total = 0;
   int bad   = 0;

   function automatic int dep(input int gi);
      return (gi == 0) ? 256 : (gi == 1) ? 16 : 1;
   endfunction

   function automatic int lat(input int gi);
      return (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
   endfunction

   function automatic logic [7:0] pat(input int d, input int a, input logic [1:0] m, input logic [7:0] fv);
      case (m)
         2'b01:   return fv;
         2'b10:   return 8'(d - 1 - a);
         default: return 8'(a);
      endcase
   endfunction

   task automatic chk(input int gi, input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL u%0d %s: got %0d expected %0d at %0t", gi, nm, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 3; g++) begin : h
      localparam int D = (g == 0) ? 256 : (g == 1) ? 16 : 1;
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

      logic [7:0] mem  [256];
      logic [7:0] pipe [4];
      logic [7:0] rd;
      int nwr   = 0;
      int noob  = 0;
      int ndone = 0;

      // reference model state: ph = cycles since accept (0 = idle)
      int         ph    = 0;
      int         ff    = -1;
      int         mma   = 0;
      bit         mv    = 1'b0;
      bit         mm    = 1'b0;
      logic [1:0] mmode = 2'b00;
      logic [7:0] mfv   = 8'h00;

      s_memory_fill #(
         .ADDR_W(8), .DATA_W(8), .DEPTH(D), .RD_LATENCY(L)
      ) dut (
         .clk           (clk),
         .reset_n       (reset_n),
         .start         (start_s[g]),
         .verify        (verify_s[g]),
         .mode          (mode_s[g]),
         .fill_value    (fv_s[g]),
         .busy          (busy_w[g]),
         .done          (done_w[g]),
         .write_enable  (we_w[g]),
         .address       (addr_w[g]),
         .wr_data       (wd_w[g]),
         .rd_data       (rd),
         .mismatch      (mm_w[g]),
         .mismatch_addr (mma_w[g])
      );

      // RAM model: writes on the strobe, read data appears L cycles after the address
      assign rd = mem[pipe[L-1]] ^ (((int'(pipe[L-1]) == ca[g]) || (int'(pipe[L-1]) == cb[g])) ? 8'h5A : 8'h00);

      always @(posedge clk) begin
         if (we_w[g]) begin
            mem[addr_w[g]] <= wd_w[g];
            nwr++;
            if (int'(addr_w[g]) >= D) noob++;
         end
         for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= addr_w[g];
      end

      // reference model: accept, step through the operation timeline, predict the first failing word
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            ph = 0; mm = 1'b0; mma = 0; mv = 1'b0; mmode = 2'b00; mfv = 8'h00; ff = -1;
         end else if (ph == 0) begin
            if (start_s[g]) begin
               ph = 1; mv = verify_s[g]; mmode = mode_s[g]; mfv = fv_s[g];
               mm = 1'b0; mma = 0; ff = -1;
               if (mv) begin
                  for (int a = D - 1; a >= 0; a--) begin
                     logic [7:0] r;
                     r = mem[a] ^ (((a == ca[g]) || (a == cb[g])) ? 8'h5A : 8'h00);
                     if (r != pat(D, a, mmode, mfv)) ff = a;
                  end
               end
            end
         end else begin
            if (ph == D + (mv ? L : 0) + 1) ph = 0;
            else ph++;
            if (mv && ff >= 0 && ph == ff + 2 + L) begin
               mm = 1'b1;
               mma = ff;
            end
         end
      end

      // compare every cycle, mid-cycle
      always @(negedge clk) begin
         int  e;
         bit  sw, dr, wexp;
         e    = D + (mv ? L : 0) + 1;
         sw   = (ph >= 1) && (ph <= D);
         dr   = mv && (ph > D) && (ph < e);
         wexp = sw && !mv;
         if (done_w[g]) ndone++;
         chk(g, "busy",  int'(busy_w[g]), int'((ph >= 1) && (ph < e)));
         chk(g, "done",  int'(done_w[g]), int'(ph == e));
         chk(g, "we",    int'(we_w[g]),   int'(wexp));
         chk(g, "addr",  int'(addr_w[g]), sw ? ph - 1 : (dr ? D - 1 : 0));
         chk(g, "wdata", int'(wd_w[g]),   wexp ? int'(pat(D, ph - 1, mmode, mfv)) : 0);
         chk(g, "mismatch", int'(mm_w[g]), int'(mm));
         if (mm) chk(g, "mismatch_addr", int'(mma_w[g]), mma);
      end
   end

   task automatic run_op(input int gi, input bit v, input logic [1:0] m, input logic [7:0] fv, output int cyc);
      @(negedge clk);
      start_s[gi] = 1'b1; verify_s[gi] = v; mode_s[gi] = m; fv_s[gi] = fv;
      @(negedge clk);
      start_s[gi] = 1'b0;
      cyc = 1;
      while (done_w[gi] !== 1'b1 && cyc < 2000) begin
         verify_s[gi] = 1'($urandom); mode_s[gi] = 2'($urandom); fv_s[gi] = 8'($urandom);
         @(negedge clk);
         cyc++;
      end
      if (done_w[gi] !== 1'b1) begin
         total++; bad++;
         $display("FAIL u%0d op_timeout: no done after %0d cycles", gi, cyc);
      end
   endtask

   // start an operation on instance gi, assert reset during its sweep cycle 100
   task automatic sweep_then_reset(input int gi, input bit v, input logic [1:0] m);
      @(negedge clk);
      start_s[gi] = 1'b1; verify_s[gi] = v; mode_s[gi] = m; fv_s[gi] = 8'h00;
      @(negedge clk);
      start_s[gi] = 1'b0;
      for (int c = 1; c < 100; c++) @(negedge clk);
      chk(gi, "pre_reset_busy", int'(busy_w[gi]), 1);
      if (v) chk(gi, "pre_reset_mismatch", int'(mm_w[gi]), 1);
      else   chk(gi, "pre_reset_we", int'(we_w[gi]), 1);
      #2 reset_n = 1'b0;
      #1;
      chk(gi, "reset_we", int'(we_w[gi]), 0);
      chk(gi, "reset_mismatch", int'(mm_w[gi]), 0);
      chk(gi, "reset_busy", int'(busy_w[gi]), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, n0, n1;
      start_s = '0; verify_s = '0; mode_s = '0; fv_s = '0;
      for (int i = 0; i < 3; i++) begin ca[i] = -1; cb[i] = -1; end
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk(0, "rst_busy", int'(busy_w), 0);
      chk(0, "rst_done", int'(done_w), 0);
      chk(0, "rst_we",   int'(we_w), 0);
      chk(0, "rst_addr", int'(addr_w), 0);
      chk(0, "rst_mismatch", int'(mm_w), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // identity fill, default geometry
      n0 = h[0].nwr;
      run_op(0, 1'b0, 2'b00, 8'h00, cyc);
      chk(0, "t1_done_cycle", cyc, 257);
      chk(0, "t1_writes", h[0].nwr - n0, 256);
      chk(0, "t1_mem37", int'(h[0].mem[8'h37]), 8'h37);
      chk(0, "t1_memff", int'(h[0].mem[8'hff]), 8'hff);

      // identity verify with two corrupted words; then recapture after clear
      ca[0] = 8'h37; cb[0] = 8'h80;
      run_op(0, 1'b1, 2'b11, 8'h00, cyc);
      chk(0, "t4_done_cycle", cyc, 258);
      chk(0, "t4_mismatch", int'(mm_w[0]), 1);
      chk(0, "t4_mismatch_addr", int'(mma_w[0]), 8'h37);
      ca[0] = -1;
      run_op(0, 1'b1, 2'b00, 8'h00, cyc);
      chk(0, "t4_recapture_addr", int'(mma_w[0]), 8'h80);
      cb[0] = -1;
      run_op(0, 1'b1, 2'b00, 8'h00, cyc);
      chk(0, "t4_cleared", int'(mm_w[0]), 0);

      // constant fill, DEPTH=16
      n0 = h[1].nwr; n1 = h[1].noob;
      run_op(1, 1'b0, 2'b01, 8'hA5, cyc);
      chk(1, "t2_done_cycle", cyc, 17);
      chk(1, "t2_writes", h[1].nwr - n0, 16);
      chk(1, "t2_oob_writes", h[1].noob - n1, 0);
      chk(1, "t2_mem0", int'(h[1].mem[0]), 8'hA5);
      chk(1, "t2_mem15", int'(h[1].mem[15]), 8'hA5);

      // reverse fill then reverse verify, RD_LATENCY=2
      run_op(1, 1'b0, 2'b10, 8'h00, cyc);
      chk(1, "t3_mem0", int'(h[1].mem[0]), 15);
      chk(1, "t3_mem15", int'(h[1].mem[15]), 0);
      run_op(1, 1'b1, 2'b10, 8'h00, cyc);
      chk(1, "t3_done_cycle", cyc, 19);
      chk(1, "t3_mismatch", int'(mm_w[1]), 0);

      // DEPTH=1, RD_LATENCY=4
      n0 = h[2].nwr;
      run_op(2, 1'b0, 2'b01, 8'h3C, cyc);
      chk(2, "d1_done_cycle", cyc, 2);
      chk(2, "d1_writes", h[2].nwr - n0, 1);
      chk(2, "d1_mem0", int'(h[2].mem[0]), 8'h3C);
      run_op(2, 1'b1, 2'b01, 8'h3C, cyc);
      chk(2, "d1_verify_cycle", cyc, 6);
      chk(2, "d1_verify_ok", int'(mm_w[2]), 0);
      run_op(2, 1'b1, 2'b00, 8'h00, cyc);
      chk(2, "d1_verify_bad", int'(mm_w[2]), 1);
      chk(2, "d1_verify_bad_addr", int'(mma_w[2]), 0);

      // reset mid-sweep: verify with early failure, then reverse fill
      n0 = h[0].ndone;
      ca[0] = 5;
      sweep_then_reset(0, 1'b1, 2'b00);
      ca[0] = -1;
      sweep_then_reset(0, 1'b0, 2'b10);
      chk(0, "t5_no_done", h[0].ndone - n0, 0);
      run_op(0, 1'b0, 2'b00, 8'h00, cyc);
      chk(0, "t5_refill_cycle", cyc, 257);
      chk(0, "t5_mem10", int'(h[0].mem[8'h10]), 8'h10);

      // start held high: two back-to-back sweeps
      n0 = h[1].ndone; n1 = h[1].nwr;
      @(negedge clk);
      start_s[1] = 1'b1; verify_s[1] = 1'b0; mode_s[1] = 2'b00;
      repeat (30) @(negedge clk);
      start_s[1] = 1'b0;
      repeat (30) @(negedge clk);
      chk(1, "t6_held_dones", h[1].ndone - n0, 2);
      chk(1, "t6_held_writes", h[1].nwr - n1, 32);

      // start pulsed while busy is ignored
      n0 = h[1].ndone; n1 = h[1].nwr;
      @(negedge clk);
      start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1] = 1'b0;
      repeat (4) @(negedge clk);
      start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1] = 1'b0;
      repeat (40) @(negedge clk);
      chk(1, "t6_pulse_dones", h[1].ndone - n0, 1);
      chk(1, "t6_pulse_writes", h[1].nwr - n1, 16);

      // random operations, model checks every cycle
      for (int it = 0; it < 40; it++) begin
         int gi;
         bit v;
         logic [1:0] m;
         logic [7:0] fv;
         gi = $urandom_range(0, 2);
         v  = 1'($urandom);
         m  = 2'($urandom);
         fv = 8'($urandom);
         ca[gi] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, dep(gi) - 1)) : -1;
         cb[gi] = -1;
         run_op(gi, v, m, fv, cyc);
         chk(gi, "rand_done_cycle", cyc, dep(gi) + (v ? lat(gi) : 0) + 1);
      end

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
